// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its RAM.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

  // Little-endian lane enables: one lane for a byte access, all lanes for a word.
  function automatic logic [WORD_BYTES-1:0] lane_be(input logic [1:0] lane,
                                                    input logic       is_byte);
    logic [WORD_BYTES-1:0] be;
    if (is_byte) be = 4'b0001 << lane;
    else         be = '1;
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-lane write enables and synchronous read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [WORD_BYTES-1:0]          be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// optional wait states, single-cycle response pulse carrying data or a fault.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WaitInit = 3'(WAIT_STATES - 1);

  dmem_state_t       state;
  logic [2:0]        cnt;
  logic              r_write;
  logic              r_byte;
  logic              r_err;
  logic [1:0]        r_lane;
  logic [IdxW-1:0]   r_idx;
  logic [31:0]       r_wdata;

  logic              fault;
  logic              ram_en;
  logic              ram_we;
  logic [WORD_BYTES-1:0] ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       rsp_data;

  // Upper address bits only feed the range check; they never reach the RAM index.
  assign fault = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                 (req_addr[31:IdxW+2] != '0);

  assign req_ready = (state == IDLE) && !reset;

  assign ram_en    = (state == ACCESS);
  assign ram_we    = (state == ACCESS) && r_write && !reset;
  assign ram_be    = lane_be(r_lane, r_byte);
  assign ram_wdata = r_byte ? {WORD_BYTES{r_wdata[7:0]}} : r_wdata;

  always_comb begin
    rsp_data = '0;
    if (!r_err && !r_write) begin
      if (r_byte) rsp_data = {24'b0, ram_rdata[{r_lane, 3'b000} +: 8]};
      else        rsp_data = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_byte  <= req_byte;
            r_lane  <= req_addr[1:0];
            r_idx   <= req_addr[2 +: IdxW];
            r_wdata <= req_wdata;
            r_err   <= fault;
            if (fault) begin
              state <= RESP;
            end else if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= WaitInit;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) state <= ACCESS;
          else             cnt   <= cnt - 3'd1;
        end
        ACCESS: state <= RESP;
        RESP: begin
          // Read data is valid from the RAM here; the response registers it out.
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= rsp_data;
          rsp_err   <= r_err;
        end
      endcase
    end
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .idx  (r_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 3 and 2 wait states) checked
// against a byte-addressed reference memory and latency rules.
module tb_dmem_responder;

  localparam int unsigned Depth = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        reset;
  logic [2:0]        req_valid;
  logic [2:0]        req_write;
  logic [2:0]        req_byte;
  logic [2:0][31:0]  req_addr;
  logic [2:0][31:0]  req_wdata;
  wire  [2:0]        req_ready;
  wire  [2:0]        rsp_valid;
  wire  [2:0]        rsp_err;
  wire  [2:0][31:0]  rsp_rdata;

  logic [7:0] mem_m [3][1024];
  int checks = 0;
  int passed = 0;

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_byte(req_byte[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_byte(req_byte[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_byte(req_byte[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: byte-addressed memory, faults leave it untouched.
  task automatic model(input int k, input logic wr, input logic by, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int a;
    e = (!by && addr[1:0] != 2'b00) || (addr >= Depth * 4);
    d = '0;
    if (!e) begin
      a = int'(addr[9:0]);
      if (wr) begin
        if (by) mem_m[k][a] = wd[7:0];
        else for (int i = 0; i < 4; i++) mem_m[k][a+i] = wd[8*i +: 8];
      end else if (by) begin
        d = {24'b0, mem_m[k][a]};
      end else begin
        d = {mem_m[k][a+3], mem_m[k][a+2], mem_m[k][a+1], mem_m[k][a]};
      end
    end
  endtask

  task automatic do_req(input int k, input logic wr, input logic by, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    logic        busy_rdy;
    int          exp_lat;
    int          n;
    model(k, wr, by, addr, wd, exp_d, exp_e);
    exp_lat = exp_e ? 1 : ws_of(k) + 2;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " ready"}, 32'(req_ready[k]), 32'd1);
    req_write[k] = wr; req_byte[k] = by; req_addr[k] = addr; req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    busy_rdy = 1'b0;
    while (rsp_valid[k] !== 1'b1 && n < 20) begin
      busy_rdy |= req_ready[k];
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy ready"}, 32'(busy_rdy), 32'd0);
    check({tag, " rdata"}, rsp_rdata[k], exp_d);
    check({tag, " err"}, 32'(rsp_err[k]), 32'(exp_e));
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(rsp_valid[k]), 32'd0);
    check({tag, " hold"}, rsp_rdata[k], exp_d);
  endtask

  // Requests held valid back-to-back; responses matched in order to the model.
  task automatic run_stream(input int k, input string tag);
    logic        wr_a [16];
    logic        by_a [16];
    logic [31:0] ad_a [16];
    logic [31:0] wd_a [16];
    logic [31:0] exp_d_q [$];
    logic        exp_e_q [$];
    int          lat_q [$];
    int          acc_q [$];
    int idx, nrsp, cyc, last_acc, gap_bad, extra, r, exp_gap;
    logic acc;
    logic [31:0] ed;
    logic ee;
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 15));
      wr_a[i] = 1'($urandom_range(0, 1));
      by_a[i] = 1'($urandom_range(0, 1));
      wd_a[i] = $urandom;
      if (r == 0) ad_a[i] = 32'h400 + 32'($urandom_range(0, 255));
      else if (r == 1 && !by_a[i]) ad_a[i] = 32'h40 + 32'($urandom_range(1, 3));
      else ad_a[i] = 32'h40 + 32'($urandom_range(0, 7)) * 4 +
                     (by_a[i] ? 32'($urandom_range(0, 3)) : 32'd0);
    end
    idx = 0; nrsp = 0; cyc = 0; last_acc = -1; gap_bad = 0; extra = 0; exp_gap = 0;
    req_write[k] = wr_a[0]; req_byte[k] = by_a[0]; req_addr[k] = ad_a[0];
    req_wdata[k] = wd_a[0]; req_valid[k] = 1'b1;
    while (nrsp < 16 && cyc < 600) begin
      acc = req_valid[k] & req_ready[k];
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid[k] === 1'b1) begin
        if (exp_d_q.size() == 0) begin
          extra++;
        end else begin
          ed = exp_d_q.pop_front();
          ee = exp_e_q.pop_front();
          check({tag, " rdata"}, rsp_rdata[k], ed);
          check({tag, " err"}, 32'(rsp_err[k]), 32'(ee));
          check({tag, " latency"}, 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
          nrsp++;
        end
      end
      if (acc) begin
        if (last_acc >= 0 && cyc - last_acc != exp_gap) gap_bad++;
        last_acc = cyc;
        model(k, wr_a[idx], by_a[idx], ad_a[idx], wd_a[idx], ed, ee);
        exp_d_q.push_back(ed);
        exp_e_q.push_back(ee);
        lat_q.push_back(ee ? 1 : ws_of(k) + 2);
        acc_q.push_back(cyc);
        exp_gap = ee ? 2 : ws_of(k) + 3;
        idx++;
        if (idx < 16) begin
          req_write[k] = wr_a[idx]; req_byte[k] = by_a[idx]; req_addr[k] = ad_a[idx];
          req_wdata[k] = wd_a[idx];
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
    req_valid[k] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[k] === 1'b1) extra++;
    end
    check({tag, " accepted"}, 32'(idx), 32'd16);
    check({tag, " responses"}, 32'(nrsp), 32'd16);
    check({tag, " accept spacing"}, 32'(gap_bad), 32'd0);
    check({tag, " extra responses"}, 32'(extra), 32'd0);
  endtask

  initial begin : main
    logic seen;
    reset = 3'b111;
    req_valid = '0; req_write = '0; req_byte = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset ready", 32'(req_ready[k]), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("reset rsp_rdata", rsp_rdata[k], 32'd0);
      check("reset rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    reset = 3'b000;
    #1;
    for (int k = 0; k < 3; k++) check("post-reset ready", 32'(req_ready[k]), 32'd1);

    // Word store/load, then byte lanes.
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "t1 store");
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, "t1 load");
    do_req(0, 1'b1, 1'b1, 32'h13, 32'h777777AB, "t2 bstore");
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, "t2 load");
    do_req(0, 1'b0, 1'b1, 32'h12, 32'h0, "t2 bload");

    // Faults and the top-of-memory boundary.
    do_req(0, 1'b1, 1'b0, 32'h000, 32'h11223344, "t3 init0");
    do_req(0, 1'b0, 1'b0, 32'h002, 32'h0, "t3 misaligned");
    do_req(0, 1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, "t3 range store");
    do_req(0, 1'b0, 1'b0, 32'h000, 32'h0, "t3 load0");
    do_req(0, 1'b1, 1'b0, 32'h3FC, 32'hA1B2C3D4, "t3 top store");
    do_req(0, 1'b0, 1'b1, 32'h3FF, 32'h0, "t3 top bload");
    do_req(0, 1'b0, 1'b1, 32'h400, 32'h0, "t3 range bload");
    do_req(0, 1'b0, 1'b0, 32'h3FE, 32'h0, "t3 top misaligned");

    // Wait states.
    do_req(1, 1'b1, 1'b0, 32'h30, 32'h0BADF00D, "t4 store");
    do_req(1, 1'b0, 1'b0, 32'h30, 32'h0, "t4 load");

    // Reset during WAIT and during ACCESS must suppress the store and the response.
    do_req(2, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, "t5 prestore");
    req_write[2] = 1'b1; req_byte[2] = 1'b0; req_addr[2] = 32'h20;
    req_wdata[2] = 32'h12345678; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    reset[2] = 1'b1;
    #1;
    check("t5 ready in reset", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    reset[2] = 1'b0;
    #1;
    check("t5 ready after reset", 32'(req_ready[2]), 32'd1);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= rsp_valid[2]; end
    check("t5 no response", 32'(seen), 32'd0);
    do_req(2, 1'b0, 1'b0, 32'h20, 32'h0, "t5 load");

    req_write[2] = 1'b1; req_byte[2] = 1'b0; req_addr[2] = 32'h20;
    req_wdata[2] = 32'h55AA55AA; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset[2] = 1'b1;
    @(posedge clk); #1;
    reset[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= rsp_valid[2]; end
    check("t5b no response", 32'(seen), 32'd0);
    do_req(2, 1'b0, 1'b0, 32'h20, 32'h0, "t5b load");

    // Back-to-back randomized streams over a preloaded region.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) do_req(k, 1'b1, 1'b0, 32'h40 + 32'(w) * 4, $urandom, "t6 fill");
    end
    run_stream(0, "t6 ws0");
    run_stream(1, "t6 ws3");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
